// File: rtl/alarm_set.sv
// Alarm-time editor: three-button UI edits shadow hour/minute (BCD) and commits them on confirm.
// Drives committed alarm time/enable plus display values and blink strobes for the edit fields.
module alarm_set #(
    parameter logic [7:0]  HR_DEFAULT     = 8'h07,
    parameter logic [7:0]  MN_DEFAULT     = 8'h00,
    parameter int unsigned HOLD_CYCLES    = 500,
    parameter int unsigned REPEAT_CYCLES  = 100,
    parameter int unsigned TIMEOUT_CYCLES = 10000,
    parameter int unsigned BLINK_CYCLES   = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [7:0] hr_alarm,
    output logic [7:0] mn_alarm,
    output logic       alarm_en,
    output logic [7:0] hr_disp,
    output logic [7:0] mn_disp,
    output logic       blink_hr,
    output logic       blink_mn
);

    localparam int unsigned CMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned BW   = $clog2(BLINK_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StSetHr, StSetMn} state_e;

    state_e        state_q, state_d;
    logic [7:0]    hr_q, hr_d, mn_q, mn_d, hr_sh_q, hr_sh_d, mn_sh_q, mn_sh_d;
    logic          en_q, en_d;
    logic          btn_mode_q, btn_up_q, btn_down_q;
    logic [CW-1:0] hold_q, hold_d;
    logic          rep_q, rep_d;
    logic [TW-1:0] idle_q, idle_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_hr_q, blink_hr_d, blink_mn_q, blink_mn_d;
    logic          mode_p, up_p, down_p, single, any_btn, do_step, blink_wrap;

    function automatic logic [7:0] bcd_step(input logic [7:0] val, input logic [7:0] lim,
                                            input logic up);
        logic [7:0] r;
        if (up) begin
            if (val == lim)             r = 8'h00;
            else if (val[3:0] == 4'd9)  r = {val[7:4] + 4'd1, 4'd0};
            else                        r = {val[7:4], val[3:0] + 4'd1};
        end else begin
            if (val == 8'h00)           r = lim;
            else if (val[3:0] == 4'd0)  r = {val[7:4] - 4'd1, 4'd9};
            else                        r = {val[7:4], val[3:0] - 4'd1};
        end
        return r;
    endfunction

    assign mode_p     = btn_mode & ~btn_mode_q;
    assign up_p       = btn_up & ~btn_up_q;
    assign down_p     = btn_down & ~btn_down_q;
    assign single     = btn_up ^ btn_down;
    assign any_btn    = btn_mode | btn_up | btn_down;
    assign blink_wrap = (blink_cnt_q == BW'(BLINK_CYCLES - 1));

    always_comb begin
        state_d  = state_q;
        hr_d     = hr_q;
        mn_d     = mn_q;
        en_d     = en_q;
        hr_sh_d  = hr_sh_q;
        mn_sh_d  = mn_sh_q;
        hold_d   = '0;
        rep_d    = 1'b0;
        idle_d   = '0;
        do_step  = 1'b0;
        if (state_q == StIdle) begin
            if (mode_p) begin
                state_d = StSetHr;
                hr_sh_d = hr_q;
                mn_sh_d = mn_q;
            end else if (up_p) begin
                en_d = ~en_q;
            end
        end else if (mode_p) begin
            if (state_q == StSetHr) begin
                state_d = StSetMn;
            end else begin
                state_d = StIdle;
                hr_d    = hr_sh_q;
                mn_d    = mn_sh_q;
                en_d    = 1'b1;
            end
        end else if (!any_btn && idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d = StIdle;
        end else begin
            if (!any_btn) idle_d = idle_q + 1'b1;
            // Hold phase counts to HOLD_CYCLES, then repeat phase reloads every REPEAT_CYCLES.
            if (single) begin
                if (up_p || down_p) begin
                    do_step = 1'b1;
                    hold_d  = CW'(1);
                end else if (!rep_q && hold_q == CW'(HOLD_CYCLES)) begin
                    do_step = 1'b1;
                    hold_d  = CW'(1);
                    rep_d   = 1'b1;
                end else if (rep_q && hold_q == CW'(REPEAT_CYCLES)) begin
                    do_step = 1'b1;
                    hold_d  = CW'(1);
                    rep_d   = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                    rep_d  = rep_q;
                end
            end
            if (do_step) begin
                if (state_q == StSetHr) hr_sh_d = bcd_step(hr_sh_q, 8'h23, btn_up);
                else                    mn_sh_d = bcd_step(mn_sh_q, 8'h59, btn_up);
            end
        end

        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_hr_d  = 1'b0;
        blink_mn_d  = 1'b0;
        if (state_d != state_q) begin
            blink_cnt_d = '0;
        end else begin
            if (blink_wrap) blink_cnt_d = '0;
            blink_hr_d = (state_q == StSetHr) & (blink_hr_q ^ blink_wrap);
            blink_mn_d = (state_q == StSetMn) & (blink_mn_q ^ blink_wrap);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            hr_q        <= HR_DEFAULT;
            mn_q        <= MN_DEFAULT;
            en_q        <= 1'b0;
            hr_sh_q     <= HR_DEFAULT;
            mn_sh_q     <= MN_DEFAULT;
            hold_q      <= '0;
            rep_q       <= 1'b0;
            idle_q      <= '0;
            blink_cnt_q <= '0;
            blink_hr_q  <= 1'b0;
            blink_mn_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hr_q        <= hr_d;
            mn_q        <= mn_d;
            en_q        <= en_d;
            hr_sh_q     <= hr_sh_d;
            mn_sh_q     <= mn_sh_d;
            hold_q      <= hold_d;
            rep_q       <= rep_d;
            idle_q      <= idle_d;
            blink_cnt_q <= blink_cnt_d;
            blink_hr_q  <= blink_hr_d;
            blink_mn_q  <= blink_mn_d;
        end
    end

    // Sampled through reset so a button held across reset release produces no edge.
    always_ff @(posedge clk) begin
        btn_mode_q <= btn_mode;
        btn_up_q   <= btn_up;
        btn_down_q <= btn_down;
    end

    assign hr_alarm = hr_q;
    assign mn_alarm = mn_q;
    assign alarm_en = en_q;
    assign hr_disp  = (state_q == StIdle) ? hr_q : hr_sh_q;
    assign mn_disp  = (state_q == StIdle) ? mn_q : mn_sh_q;
    assign blink_hr = blink_hr_q;
    assign blink_mn = blink_mn_q;

endmodule

// File: tb/tb_alarm_set.sv
// Scoreboard bench for alarm_set: a decimal-arithmetic model predicts every cycle's outputs,
// a monitor compares them after each clock edge; directed scenarios add fixed-value checks.
module tb_alarm_set;

    localparam int HOLD = 4;
    localparam int REP  = 2;
    localparam int TMO  = 50;
    localparam int BLK  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic [7:0] hr_alarm, mn_alarm, hr_disp, mn_disp;
    logic       alarm_en, blink_hr, blink_mn;

    alarm_set #(
        .HR_DEFAULT    (8'h07),
        .MN_DEFAULT    (8'h00),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP),
        .TIMEOUT_CYCLES(TMO),
        .BLINK_CYCLES  (BLK)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_mode(btn_mode),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .hr_alarm(hr_alarm),
        .mn_alarm(mn_alarm),
        .alarm_en(alarm_en),
        .hr_disp (hr_disp),
        .mn_disp (mn_disp),
        .blink_hr(blink_hr),
        .blink_mn(blink_mn)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] hra, mna, hrd, mnd;
        logic       en, bh, bm;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Model state: mode 0=idle 1=edit hour 2=edit minute; times as plain integers.
    int m_st, m_hr, m_mn, m_en, m_shh, m_shm, m_held, m_idle, m_k;
    bit pm, pu, pd;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit m, input bit u, input bit d);
        int nst;
        bit mp, upp, dnp, step;
        if (r) begin
            m_st = 0; m_hr = 7; m_mn = 0; m_en = 0; m_shh = 7; m_shm = 0;
            m_held = 0; m_idle = 0; m_k = 0;
            pm = m; pu = u; pd = d;
            return;
        end
        mp  = m && !pm;
        upp = u && !pu;
        dnp = d && !pd;
        pm = m; pu = u; pd = d;
        nst = m_st;
        if (m_st == 0) begin
            m_held = 0; m_idle = 0;
            if (mp) begin
                nst = 1; m_shh = m_hr; m_shm = m_mn;
            end else if (upp) begin
                m_en = !m_en;
            end
        end else if (mp) begin
            m_held = 0; m_idle = 0;
            if (m_st == 1) nst = 2;
            else begin
                nst = 0; m_hr = m_shh; m_mn = m_shm; m_en = 1;
            end
        end else if (!(m || u || d) && m_idle + 1 >= TMO) begin
            nst = 0; m_held = 0; m_idle = 0;
        end else begin
            m_idle = (m || u || d) ? 0 : m_idle + 1;
            if (u != d) begin
                step = upp || dnp || (m_held >= HOLD && (m_held - HOLD) % REP == 0);
                m_held = (upp || dnp) ? 1 : m_held + 1;
                if (step) begin
                    if (m_st == 1) m_shh = u ? (m_shh + 1) % 24 : (m_shh + 23) % 24;
                    else           m_shm = u ? (m_shm + 1) % 60 : (m_shm + 59) % 60;
                end
            end else begin
                m_held = 0;
            end
        end
        m_k  = (nst != m_st) ? 0 : m_k + 1;
        m_st = nst;
    endtask

    function automatic exp_t expected();
        exp_t e;
        e.hra = to_bcd(m_hr);
        e.mna = to_bcd(m_mn);
        e.en  = (m_en != 0);
        e.hrd = (m_st == 0) ? to_bcd(m_hr) : to_bcd(m_shh);
        e.mnd = (m_st == 0) ? to_bcd(m_mn) : to_bcd(m_shm);
        e.bh  = (m_st == 1) && ((m_k / BLK) % 2 == 1);
        e.bm  = (m_st == 2) && ((m_k / BLK) % 2 == 1);
        return e;
    endfunction

    // One clock: drive at negedge, predict, then return just after the edge and the monitor.
    task automatic cyc(input bit r, input bit m, input bit u, input bit d);
        @(negedge clk);
        rst = r; btn_mode = m; btn_up = u; btn_down = d;
        model_step(r, m, u, d);
        q.push_back(expected());
        @(posedge clk);
        #2;
    endtask

    task automatic press(input bit m, input bit u, input bit d);
        cyc(0, m, u, d);
        cyc(0, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("sb_hr_alarm", hr_alarm, e.hra);
                cmp("sb_mn_alarm", mn_alarm, e.mna);
                cmp("sb_alarm_en", {7'd0, alarm_en}, {7'd0, e.en});
                cmp("sb_hr_disp", hr_disp, e.hrd);
                cmp("sb_mn_disp", mn_disp, e.mnd);
                cmp("sb_blink_hr", {7'd0, blink_hr}, {7'd0, e.bh});
                cmp("sb_blink_mn", {7'd0, blink_mn}, {7'd0, e.bm});
            end
        end
    end

    initial begin : stim
        logic rm, ru, rd;
        rm = 0; ru = 0; rd = 0;
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
        cmp("rst_hr", hr_alarm, 8'h07);
        cmp("rst_mn", mn_alarm, 8'h00);
        cmp("rst_en", {7'd0, alarm_en}, 8'd0);
        press(0, 1, 0);
        cmp("idle_up_en1", {7'd0, alarm_en}, 8'd1);
        press(0, 1, 0);
        cmp("idle_up_en0", {7'd0, alarm_en}, 8'd0);

        press(1, 0, 0);
        for (int i = 0; i < 3; i++) press(0, 1, 0);
        cmp("edit_hr_disp", hr_disp, 8'h10);
        cmp("edit_hr_hold", hr_alarm, 8'h07);
        press(1, 0, 0);
        press(0, 0, 1);
        press(0, 0, 1);
        cmp("edit_pre_commit", hr_alarm, 8'h07);
        press(1, 0, 0);
        cmp("commit_hr", hr_alarm, 8'h10);
        cmp("commit_mn", mn_alarm, 8'h58);
        cmp("commit_en", {7'd0, alarm_en}, 8'd1);

        press(1, 0, 0);
        for (int i = 0; i < 13; i++) press(0, 1, 0);
        cmp("hr_23", hr_disp, 8'h23);
        press(0, 1, 0);
        cmp("hr_wrap_up", hr_disp, 8'h00);
        press(0, 0, 1);
        cmp("hr_wrap_dn", hr_disp, 8'h23);
        press(1, 0, 0);
        press(0, 1, 0);
        press(0, 1, 0);
        cmp("mn_wrap_up", mn_disp, 8'h00);
        cmp("mn_wrap_nocarry", hr_disp, 8'h23);
        for (int i = 0; i < 9; i++) press(0, 1, 0);
        cmp("mn_09", mn_disp, 8'h09);
        press(0, 1, 0);
        cmp("mn_carry", mn_disp, 8'h10);
        press(1, 0, 0);
        cmp("commit2_hr", hr_alarm, 8'h23);

        press(1, 0, 0);
        press(1, 0, 0);
        for (int i = 0; i < 10; i++) press(0, 0, 1);
        cmp("mn_00", mn_disp, 8'h00);
        for (int i = 0; i < 12; i++) cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        cmp("repeat_05", mn_disp, 8'h05);
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 1);
        cyc(0, 0, 0, 0);
        cmp("up_down_nostep", mn_disp, 8'h05);
        press(1, 0, 0);
        cmp("commit3_mn", mn_alarm, 8'h05);

        cyc(1, 0, 0, 0);
        press(1, 0, 0);
        idle(7);
        cmp("blink_hr_on", {7'd0, blink_hr}, 8'd1);
        cmp("blink_mn_off", {7'd0, blink_mn}, 8'd0);
        press(0, 1, 0);
        press(0, 1, 0);
        idle(48);
        cmp("timeout_edge", hr_disp, 8'h09);
        idle(1);
        cmp("timeout_disp", hr_disp, 8'h07);
        cmp("timeout_hr", hr_alarm, 8'h07);
        press(0, 1, 0);
        cmp("en_before_rst", {7'd0, alarm_en}, 8'd1);
        press(1, 0, 0);
        press(1, 0, 0);
        press(0, 1, 0);
        cyc(1, 0, 0, 0);
        cmp("midrst_hr", hr_alarm, 8'h07);
        cmp("midrst_mn", mn_alarm, 8'h00);
        cmp("midrst_en", {7'd0, alarm_en}, 8'd0);
        cmp("midrst_mn_disp", mn_disp, 8'h00);

        press(1, 0, 0);
        cyc(0, 1, 1, 0);
        cyc(0, 0, 0, 0);
        cmp("mode_prio_hr", hr_disp, 8'h07);
        press(1, 0, 0);
        cmp("mode_prio_commit", hr_alarm, 8'h07);
        cyc(1, 0, 1, 0);
        cyc(1, 0, 1, 0);
        cyc(0, 0, 1, 0);
        cmp("held_thru_rst", {7'd0, alarm_en}, 8'd0);
        cyc(0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            if ((i % 400) >= 330) begin
                rm = 0; ru = 0; rd = 0;
                cyc(0, 0, 0, 0);
            end else begin
                if ($urandom_range(15) == 0) rm = ~rm;
                if ($urandom_range(7) == 0)  ru = ~ru;
                if ($urandom_range(7) == 0)  rd = ~rd;
                cyc($urandom_range(499) == 0, rm, ru, rd);
            end
        end

        idle(2);
        cmp("sb_drained", 8'(q.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
